// File: rtl/axis_packet_demux_if.sv
// AXI-Stream bus interface (axis_if) used by axis_packet_demux.
// TDATA, TVALID, TREADY and TLAST are always present; TSTRB, TKEEP, TID,
// TDEST and TUSER are compiled in by TSTRB_PRESENT, TKEEP_PRESENT,
// TID_PRESENT, TDEST_PRESENT and TUSER_PRESENT.
interface axis_if #(
    parameter int DATA_WIDTH = 32
`ifdef TID_PRESENT
    , parameter int ID_WIDTH = 4
`endif
`ifdef TDEST_PRESENT
    , parameter int DEST_WIDTH = 4
`endif
`ifdef TUSER_PRESENT
    , parameter int USER_WIDTH = 4
`endif
);
    logic                    TVALID;
    logic                    TREADY;
    logic [DATA_WIDTH-1:0]   TDATA;
    logic                    TLAST;
`ifdef TSTRB_PRESENT
    logic [DATA_WIDTH/8-1:0] TSTRB;
`endif
`ifdef TKEEP_PRESENT
    logic [DATA_WIDTH/8-1:0] TKEEP;
`endif
`ifdef TID_PRESENT
    logic [ID_WIDTH-1:0]     TID;
`endif
`ifdef TDEST_PRESENT
    logic [DEST_WIDTH-1:0]   TDEST;
`endif
`ifdef TUSER_PRESENT
    logic [USER_WIDTH-1:0]   TUSER;
`endif

    modport m (output TVALID, output TDATA, output TLAST
`ifdef TSTRB_PRESENT
        , output TSTRB
`endif
`ifdef TKEEP_PRESENT
        , output TKEEP
`endif
`ifdef TID_PRESENT
        , output TID
`endif
`ifdef TDEST_PRESENT
        , output TDEST
`endif
`ifdef TUSER_PRESENT
        , output TUSER
`endif
        , input TREADY);

    modport s (input TVALID, input TDATA, input TLAST
`ifdef TSTRB_PRESENT
        , input TSTRB
`endif
`ifdef TKEEP_PRESENT
        , input TKEEP
`endif
`ifdef TID_PRESENT
        , input TID
`endif
`ifdef TDEST_PRESENT
        , input TDEST
`endif
`ifdef TUSER_PRESENT
        , input TUSER
`endif
        , output TREADY);
endinterface

// File: rtl/axis_packet_demux.sv
// Packet-aware AXI-Stream 1-to-N demux with one FIFO per output channel.
// The route is latched at the first beat and held until TLAST; packets to
// an out-of-range channel are swallowed. Optional per-channel packet
// counters are compiled in with AXIS_DEMUX_PMU_EN.
module axis_packet_demux #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int AXIS_DATA_WIDTH      = 32,
    parameter int BUFFER_DEPTH         = 2
`ifdef TID_PRESENT
    , parameter int ID_WIDTH           = 4
`endif
`ifdef TDEST_PRESENT
    , parameter int DEST_WIDTH         = 4
`endif
`ifdef TUSER_PRESENT
    , parameter int USER_WIDTH         = 4
`endif
`ifdef AXIS_DEMUX_PMU_EN
    , parameter int PMU_CNT_WIDTH      = 16
`endif
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    axis_if.s                               in,
    input  logic                            en,
    input  logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl,
    axis_if.m                               out [CHANNEL_NUMBER],
    output logic                            busy_o,
    output logic                            drop_o
`ifdef AXIS_DEMUX_PMU_EN
    , input  logic                          pmu_clr_i,
    output logic [CHANNEL_NUMBER-1:0][PMU_CNT_WIDTH-1:0] pkt_cnt_o
`endif
);
    // Stored beat: {TDATA, TLAST, optional sideband fields}
    localparam int PW = AXIS_DATA_WIDTH + 1
`ifdef TSTRB_PRESENT
        + AXIS_DATA_WIDTH/8
`endif
`ifdef TKEEP_PRESENT
        + AXIS_DATA_WIDTH/8
`endif
`ifdef TID_PRESENT
        + ID_WIDTH
`endif
`ifdef TDEST_PRESENT
        + DEST_WIDTH
`endif
`ifdef TUSER_PRESENT
        + USER_WIDTH
`endif
        ;
    localparam int PTRW = $clog2(BUFFER_DEPTH);
    localparam int CW   = PTRW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]                      state;
    logic [CHANNEL_NUMBER_WIDTH-1:0] sel_q;
    logic [CHANNEL_NUMBER-1:0]       full;
    logic                            sel_full;
    logic                            hs_in;
    logic                            ctrl_ok;
    logic [PW-1:0]                   in_pl;

    assign in_pl = {in.TDATA, in.TLAST
`ifdef TSTRB_PRESENT
        , in.TSTRB
`endif
`ifdef TKEEP_PRESENT
        , in.TKEEP
`endif
`ifdef TID_PRESENT
        , in.TID
`endif
`ifdef TDEST_PRESENT
        , in.TDEST
`endif
`ifdef TUSER_PRESENT
        , in.TUSER
`endif
        };

    assign ctrl_ok = (32'(ctrl) < 32'(CHANNEL_NUMBER));
    assign hs_in   = in.TVALID && in.TREADY;
    assign busy_o  = (state != ST_IDLE);

    // Fullness of the latched channel, looked up without an out-of-range index
    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < CHANNEL_NUMBER; i++)
            if (sel_q == CHANNEL_NUMBER_WIDTH'(i)) sel_full = full[i];
    end

    // Input ready depends only on registered state and counts
    always_comb begin
        in.TREADY = 1'b0;
        case (state)
            ST_FWD:  in.TREADY = !sel_full;
            ST_DROP: in.TREADY = 1'b1;
            default: in.TREADY = 1'b0;
        endcase
    end

    // Packet FSM: latch route in IDLE (one bubble), release on TLAST handshake
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state  <= ST_IDLE;
            sel_q  <= '0;
            drop_o <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            case (state)
                ST_IDLE: if (en && in.TVALID) begin
                    sel_q <= ctrl;
                    if (ctrl_ok) begin
                        state <= ST_FWD;
                    end else begin
                        state  <= ST_DROP;
                        drop_o <= 1'b1;
                    end
                end
                ST_FWD, ST_DROP: if (hs_in && in.TLAST) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_ch
        logic [PW-1:0]   mem [BUFFER_DEPTH];
        logic [PTRW-1:0] rd, wr;
        logic [CW-1:0]   cnt;
        logic            vld, push, pop;
        logic [PW-1:0]   head;

        assign vld     = (cnt != '0);
        assign push    = hs_in && (state == ST_FWD) && (sel_q == CHANNEL_NUMBER_WIDTH'(g));
        assign pop     = vld && out[g].TREADY;
        assign full[g] = (cnt == CW'(BUFFER_DEPTH));
        // Empty FIFO presents an all-zero payload
        assign head    = vld ? mem[rd] : '0;

        assign out[g].TVALID = vld;
        assign {out[g].TDATA, out[g].TLAST
`ifdef TSTRB_PRESENT
            , out[g].TSTRB
`endif
`ifdef TKEEP_PRESENT
            , out[g].TKEEP
`endif
`ifdef TID_PRESENT
            , out[g].TID
`endif
`ifdef TDEST_PRESENT
            , out[g].TDEST
`endif
`ifdef TUSER_PRESENT
            , out[g].TUSER
`endif
            } = head;

        // Per-channel FIFO; pointers wrap naturally at power-of-2 depth
        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                rd  <= '0;
                wr  <= '0;
                cnt <= '0;
                for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
            end else begin
                if (push) begin
                    mem[wr] <= in_pl;
                    wr      <= wr + 1'b1;
                end
                if (pop) rd <= rd + 1'b1;
                if (push && !pop)      cnt <= cnt + 1'b1;
                else if (!push && pop) cnt <= cnt - 1'b1;
            end
        end

`ifdef AXIS_DEMUX_PMU_EN
        logic [PMU_CNT_WIDTH-1:0] pc;
        assign pkt_cnt_o[g] = pc;

        // Saturating count of packets leaving this channel; clear wins
        always_ff @(posedge ACLK) begin
            if (ARESET || pmu_clr_i) pc <= '0;
            else if (pop && out[g].TLAST && (pc != '1)) pc <= pc + 1'b1;
        end
`endif
    end
endmodule
